// File: rtl/sr_latch_ctrl_if.sv
// rtl/sr_latch_ctrl_if.sv - requester handshake and latch drive/readback bundle for sr_latch_ctrl
interface sr_latch_ctrl_if;
   logic req0;
   logic req1;
   logic op0;
   logic op1;
   logic ack0;
   logic ack1;
   logic err;
   logic s;
   logic r;
   logic q;
   logic q_bar;
   logic busy;
   logic fault;

   modport master (
      output req0, req1, op0, op1, q, q_bar,
      input  ack0, ack1, err, s, r, busy, fault
   );

   modport slave (
      input  req0, req1, op0, op1, q, q_bar,
      output ack0, ack1, err, s, r, busy, fault
   );
endinterface

// File: rtl/sr_latch_ctrl.sv
// rtl/sr_latch_ctrl.sv - two-requester arbiter driving a shared SR latch with timed pulses and readback check
module sr_latch_ctrl #(
   parameter int PULSE_W = 2,
   parameter int GAP_W   = 1
) (
   input logic          clk,
   input logic          rst,
   sr_latch_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2,
      CHECK = 2'd3
   } state_t;

   localparam logic [3:0] PULSE_LD = 4'(PULSE_W - 1);
   localparam logic [3:0] GAP_LD   = 4'(GAP_W - 1);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] pulse_cnt;
   logic [3:0] pulse_cnt_nxt;
   logic [3:0] gap_cnt;
   logic [3:0] gap_cnt_nxt;
   logic       op_r;
   logic       op_nxt;
   logic       gnt_r;
   logic       gnt_nxt;
   logic       prio_r;
   logic       prio_nxt;
   logic       pick;
   logic       mism;

   logic       s_q;
   logic       r_q;
   logic       ack0_q;
   logic       ack1_q;
   logic       err_q;
   logic       busy_q;
   logic       fault_q;
   logic       s_nxt;
   logic       r_nxt;
   logic       ack0_nxt;
   logic       ack1_nxt;
   logic       err_nxt;
   logic       busy_nxt;
   logic       fault_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pulse_cnt <= 4'd0;
         gap_cnt   <= 4'd0;
         op_r      <= 1'b0;
         gnt_r     <= 1'b0;
         prio_r    <= 1'b0;
         s_q       <= 1'b0;
         r_q       <= 1'b0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         pulse_cnt <= pulse_cnt_nxt;
         gap_cnt   <= gap_cnt_nxt;
         op_r      <= op_nxt;
         gnt_r     <= gnt_nxt;
         prio_r    <= prio_nxt;
         s_q       <= s_nxt;
         r_q       <= r_nxt;
         ack0_q    <= ack0_nxt;
         ack1_q    <= ack1_nxt;
         err_q     <= err_nxt;
         busy_q    <= busy_nxt;
         fault_q   <= fault_nxt;
      end
   end

   // prio_r names the requester that wins a tie; it always points away from the last grant.
   always_comb begin
      state_nxt     = state;
      pulse_cnt_nxt = pulse_cnt;
      gap_cnt_nxt   = gap_cnt;
      op_nxt        = op_r;
      gnt_nxt       = gnt_r;
      prio_nxt      = prio_r;
      pick          = 1'b0;

      case (state)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               pick          = (bus.req0 && bus.req1) ? prio_r : bus.req1;
               op_nxt        = pick ? bus.op1 : bus.op0;
               gnt_nxt       = pick;
               prio_nxt      = ~pick;
               pulse_cnt_nxt = PULSE_LD;
               state_nxt     = PULSE;
            end
         end
         PULSE: begin
            if (pulse_cnt == 4'd0) begin
               gap_cnt_nxt = GAP_LD;
               state_nxt   = GAP;
            end else begin
               pulse_cnt_nxt = pulse_cnt - 4'd1;
            end
         end
         GAP: begin
            if (gap_cnt == 4'd0) begin
               state_nxt = CHECK;
            end else begin
               gap_cnt_nxt = gap_cnt - 4'd1;
            end
         end
         CHECK: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Outputs are computed from the next state so they register in step with it;
   // the readback is sampled on the edge that enters CHECK, after the full gap.
   always_comb begin
      s_nxt     = 1'b0;
      r_nxt     = 1'b0;
      ack0_nxt  = 1'b0;
      ack1_nxt  = 1'b0;
      err_nxt   = 1'b0;
      busy_nxt  = 1'b0;
      fault_nxt = fault_q;
      mism      = (bus.q != op_r) || (bus.q_bar != ~op_r);

      if (state_nxt == PULSE) begin
         s_nxt = op_nxt;
         r_nxt = ~op_nxt;
      end
      if (state_nxt == CHECK) begin
         ack0_nxt = ~gnt_nxt;
         ack1_nxt = gnt_nxt;
         err_nxt  = mism;
      end
      busy_nxt  = (state_nxt != IDLE);
      fault_nxt = fault_q | err_nxt;
   end

   assign bus.s     = s_q;
   assign bus.r     = r_q;
   assign bus.ack0  = ack0_q;
   assign bus.ack1  = ack1_q;
   assign bus.err   = err_q;
   assign bus.busy  = busy_q;
   assign bus.fault = fault_q;

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// tb/tb_sr_latch_ctrl.sv - scoreboard bench for sr_latch_ctrl with a timed behavioural model
module tb_sr_latch_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sr_latch_ctrl_if ifa ();
   sr_latch_ctrl_if ifb ();

   sr_latch_ctrl #(.PULSE_W(2), .GAP_W(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
   sr_latch_ctrl #(.PULSE_W(1), .GAP_W(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

   logic       sel   = 1'b0;
   logic [1:0] req_d = 2'b00;
   logic [1:0] op_d  = 2'b00;
   logic       stuck = 1'b0;
   logic       q_m   = 1'b0;
   logic       q_l;

   assign ifa.req0 = ~sel & req_d[0];
   assign ifa.req1 = ~sel & req_d[1];
   assign ifb.req0 = sel & req_d[0];
   assign ifb.req1 = sel & req_d[1];
   assign ifa.op0  = op_d[0];
   assign ifa.op1  = op_d[1];
   assign ifb.op0  = op_d[0];
   assign ifb.op1  = op_d[1];

   logic s_m, r_m, ack0_m, ack1_m, err_m, busy_m, fault_m;
   assign s_m     = sel ? ifb.s     : ifa.s;
   assign r_m     = sel ? ifb.r     : ifa.r;
   assign ack0_m  = sel ? ifb.ack0  : ifa.ack0;
   assign ack1_m  = sel ? ifb.ack1  : ifa.ack1;
   assign err_m   = sel ? ifb.err   : ifa.err;
   assign busy_m  = sel ? ifb.busy  : ifa.busy;
   assign fault_m = sel ? ifb.fault : ifa.fault;

   // Behavioural SR latch; "stuck" pins q low to emulate a broken cell.
   always @(s_m or r_m) begin
      if (s_m) q_m = 1'b1;
      else if (r_m) q_m = 1'b0;
   end
   assign q_l       = stuck ? 1'b0 : q_m;
   assign ifa.q     = q_l;
   assign ifa.q_bar = ~q_l;
   assign ifb.q     = q_l;
   assign ifb.q_bar = ~q_l;

   typedef struct {
      int idx;
      int op;
      int err;
      int at;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   pend0[$];
   int   pend1[$];
   int   p_w = 2;
   int   g_w = 1;
   int   cyc = 0;
   int   next_free = 0;
   int   busy_lo = 1;
   int   busy_hi = 0;
   int   last_g = -1;
   int   g;
   int   saw_ack[2] = '{0, 0};
   int   wait_cnt[2] = '{0, 0};
   int   scnt = 0;
   int   rcnt = 0;
   logic fault_exp = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   task automatic chk(input string nm, input int act, input int exp_v);
      vectors++;
      if (act != exp_v) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   function automatic int pend_size(input int i);
      return (i == 0) ? pend0.size() : pend1.size();
   endfunction

   function automatic int pend_pop(input int i);
      if (i == 0) return pend0.pop_front();
      return pend1.pop_front();
   endfunction

   // Timed model: a grant at edge k occupies the block until edge k+P+G+2, acks at k+P+G+1.
   always @(posedge clk) begin
      if (rst) begin
         next_free = 0;
         busy_lo   = 1;
         busy_hi   = 0;
         last_g    = -1;
      end else if (cyc >= next_free && (req_d[0] || req_d[1])) begin
         if (req_d[0] && req_d[1]) g = (last_g == 0) ? 1 : 0;
         else g = req_d[1] ? 1 : 0;
         last_g  = g;
         e.idx   = g;
         e.op    = int'(op_d[g]);
         e.err   = (stuck && op_d[g]) ? 1 : 0;
         e.at    = cyc + p_w + g_w + 1;
         sb.push_back(e);
         busy_lo   = cyc + 1;
         busy_hi   = cyc + p_w + g_w + 1;
         next_free = cyc + p_w + g_w + 2;
      end
      cyc <= cyc + 1;
   end

   // Requesters: hold req until ack, then drop it or reuse it for a queued follow-up.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            req_d[i]    = 1'b0;
            wait_cnt[i] = 0;
            saw_ack[i]  = 0;
            if (i == 0) pend0.delete();
            else pend1.delete();
         end else if (req_d[i]) begin
            if (saw_ack[i] != 0) begin
               saw_ack[i]  = 0;
               wait_cnt[i] = 0;
               if (pend_size(i) > 0) op_d[i] = pend_pop(i) != 0;
               else req_d[i] = 1'b0;
            end else begin
               wait_cnt[i]++;
               if (wait_cnt[i] > 100) begin
                  chk("req_timeout", 0, 1);
                  req_d[i]    = 1'b0;
                  wait_cnt[i] = 0;
               end
            end
         end else if (pend_size(i) > 0) begin
            op_d[i]  = pend_pop(i) != 0;
            req_d[i] = 1'b1;
         end
      end
   end

   exp_t m;
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         fault_exp = 1'b0;
         scnt = 0;
         rcnt = 0;
      end
      chk("s_r_excl", int'(s_m & r_m), 0);
      chk("busy", int'(busy_m), (!rst && cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
      chk("both_ack", int'(ack0_m & ack1_m), 0);
      if (!ack0_m && !ack1_m) chk("err_no_ack", int'(err_m), 0);
      chk("idle_dut_quiet", sel ? int'(ifa.ack0 | ifa.ack1 | ifa.s | ifa.r)
                                : int'(ifb.ack0 | ifb.ack1 | ifb.s | ifb.r), 0);
      if (s_m) scnt++;
      if (r_m) rcnt++;
      if (ack0_m || ack1_m) begin
         if (sb.size() == 0) begin
            chk("unexpected_ack", 1, 0);
         end else begin
            m = sb.pop_front();
            chk("ack_idx", ack1_m ? 1 : 0, m.idx);
            chk("ack_cycle", cyc, m.at);
            chk("err", int'(err_m), m.err);
            chk("s_cycles", scnt, (m.op != 0) ? p_w : 0);
            chk("r_cycles", rcnt, (m.op != 0) ? 0 : p_w);
            if (m.err != 0) fault_exp = 1'b1;
         end
         saw_ack[ack1_m ? 1 : 0] = 1;
         scnt = 0;
         rcnt = 0;
      end
      if (sb.size() > 0 && cyc > sb[0].at) begin
         chk("ack_missing", 0, 1);
         void'(sb.pop_front());
      end
      chk("fault", int'(fault_m), int'(fault_exp));
   end

   task automatic wait_drain(input int limit);
      int n;
      n = 0;
      while ((pend0.size() != 0 || pend1.size() != 0 || req_d != 2'b00 || sb.size() != 0) && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", (n < limit) ? 1 : 0, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("rst_s", int'(s_m), 0);
      chk("rst_r", int'(r_m), 0);
      chk("rst_ack0", int'(ack0_m), 0);
      chk("rst_ack1", int'(ack1_m), 0);
      chk("rst_err", int'(err_m), 0);
      chk("rst_busy", int'(busy_m), 0);
      chk("rst_fault", int'(fault_m), 0);
      rst = 1'b0;
      @(negedge clk);

      // Single set request with defaults.
      pend0.push_back(1);
      wait_drain(100);

      // Simultaneous requests after reset; requester 0 re-requests right after its ack.
      do_reset();
      pend0.push_back(1);
      pend0.push_back(1);
      pend1.push_back(0);
      wait_drain(200);

      // Stuck-at-0 latch gives err and a sticky fault that survives a clean op.
      stuck = 1'b1;
      pend1.push_back(1);
      wait_drain(100);
      stuck = 1'b0;
      pend0.push_back(0);
      wait_drain(100);
      chk("fault_sticky", int'(fault_m), 1);

      // Reset in the middle of PULSE.
      pend0.push_back(1);
      n = 0;
      while (!s_m && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("pulse_seen", int'(s_m), 1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_s", int'(s_m), 0);
      chk("async_r", int'(r_m), 0);
      chk("async_busy", int'(busy_m), 0);
      chk("async_ack", int'(ack0_m | ack1_m), 0);
      chk("async_fault", int'(fault_m), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // Random traffic on the PULSE_W=1, GAP_W=3 instance.
      @(negedge clk);
      rst = 1'b1;
      sel = 1'b1;
      p_w = 1;
      g_w = 3;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         if (pend0.size() == 0 && $urandom_range(0, 3) == 0) pend0.push_back(int'($urandom_range(0, 1)));
         if (pend1.size() == 0 && $urandom_range(0, 3) == 0) pend1.push_back(int'($urandom_range(0, 1)));
      end
      wait_drain(400);
      chk("sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
